// File: rtl/cpu_types_pkg.sv
// Shared CPU types: register index, pipeline controller FSM state and the
// bundle of latch/PC control strobes produced by the stall/flush sequencer.
package cpu_types_pkg;

   localparam int REG_W = 5;

   typedef logic [REG_W-1:0] regbits_t;

   typedef enum logic [1:0] {
      RUN    = 2'd0,
      DWAIT  = 2'd1,
      HALTED = 2'd2
   } ctrl_state_t;

   typedef struct packed {
      logic pc_en;
      logic ifid_en;
      logic idex_en;
      logic exmem_en;
      logic memwb_en;
      logic ifid_flush;
      logic idex_flush;
      logic exmem_flush;
      logic memwb_flush;
   } latch_ctrl_t;

   localparam latch_ctrl_t CTRL_FREEZE  = '0;
   localparam latch_ctrl_t CTRL_ADVANCE = '{pc_en: 1'b1, ifid_en: 1'b1, idex_en: 1'b1,
                                            exmem_en: 1'b1, memwb_en: 1'b1, default: 1'b0};

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Bundle of every pipeline_ctrl signal; the pc modport is the controller's view.
interface pipeline_ctrl_if
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input logic CLK,
   input logic nRST
);
   logic             ihit;
   logic             dhit;
   logic             mem_dREN;
   logic             mem_dWEN;
   logic             ex_dREN;
   regbits_t         ex_wsel;
   regbits_t         id_rs;
   regbits_t         id_rt;
   logic             redirect;
   logic             wb_halt;
   logic             pc_en;
   logic             ifid_en;
   logic             idex_en;
   logic             exmem_en;
   logic             memwb_en;
   logic             ifid_flush;
   logic             idex_flush;
   logic             exmem_flush;
   logic             memwb_flush;
   logic             halt;
   ctrl_state_t      ctrl_state;
   logic [CNT_W-1:0] stall_cnt;

   modport pc (
      input  CLK, nRST, ihit, dhit, mem_dREN, mem_dWEN, ex_dREN, ex_wsel,
             id_rs, id_rt, redirect, wb_halt,
      output pc_en, ifid_en, idex_en, exmem_en, memwb_en,
             ifid_flush, idex_flush, exmem_flush, memwb_flush,
             halt, ctrl_state, stall_cnt
   );
endinterface

// File: rtl/pipeline_ctrl_hazard_detect.sv
// Load-use comparator: EX-stage load whose destination feeds an ID-stage source.
module hazard_detect
   import cpu_types_pkg::*;
(
   input  logic     ex_dREN,
   input  regbits_t ex_wsel,
   input  regbits_t id_rs,
   input  regbits_t id_rt,
   output logic     load_use
);
   regbits_t   src [2];
   logic [1:0] match;

   assign src[0] = id_rs;
   assign src[1] = id_rt;

   generate
      for (genvar gi = 0; gi < 2; gi++) begin : g_src_cmp
         assign match[gi] = (ex_wsel == src[gi]);
      end
   endgenerate

   // Register 0 is hardwired, so a load targeting it never creates a dependency.
   assign load_use = ex_dREN & (ex_wsel != '0) & (|match);
endmodule

// File: rtl/pipeline_ctrl.sv
// Five-stage pipeline stall/flush sequencer: latch enables/flushes, PC enable,
// outstanding-access FSM, sticky halt and a saturating stall-cycle counter.
module pipeline_ctrl
   import cpu_types_pkg::*;
#(
   parameter int CNT_W = 16
) (
   input  logic             CLK,
   input  logic             nRST,
   input  logic             ihit,
   input  logic             dhit,
   input  logic             mem_dREN,
   input  logic             mem_dWEN,
   input  logic             ex_dREN,
   input  regbits_t         ex_wsel,
   input  regbits_t         id_rs,
   input  regbits_t         id_rt,
   input  logic             redirect,
   input  logic             wb_halt,
   output logic             pc_en,
   output logic             ifid_en,
   output logic             idex_en,
   output logic             exmem_en,
   output logic             memwb_en,
   output logic             ifid_flush,
   output logic             idex_flush,
   output logic             exmem_flush,
   output logic             memwb_flush,
   output logic             halt,
   output ctrl_state_t      ctrl_state,
   output logic [CNT_W-1:0] stall_cnt
);
   logic             mem_op;
   logic             mem_stall;
   logic             advance;
   logic             load_use;
   ctrl_state_t      state_reg, state_next;
   logic             halt_reg, halt_next;
   logic [CNT_W-1:0] stall_cnt_reg, stall_cnt_next;
   latch_ctrl_t      ctl;

   assign mem_op    = mem_dREN | mem_dWEN;
   assign mem_stall = mem_op & ~dhit;
   assign advance   = ihit & ~mem_stall;

   hazard_detect u_hazard_detect (
      .ex_dREN  (ex_dREN),
      .ex_wsel  (ex_wsel),
      .id_rs    (id_rs),
      .id_rt    (id_rt),
      .load_use (load_use)
   );

   always_ff @(posedge CLK or negedge nRST) begin
      if (!nRST) begin
         state_reg     <= RUN;
         halt_reg      <= 1'b0;
         stall_cnt_reg <= '0;
      end else begin
         state_reg     <= state_next;
         halt_reg      <= halt_next;
         stall_cnt_reg <= stall_cnt_next;
      end
   end

   always_comb begin
      ctl        = CTRL_FREEZE;
      state_next = state_reg;

      if (state_reg == HALTED || wb_halt || mem_stall) begin
         ctl = CTRL_FREEZE;
      end else if (mem_op && !ihit) begin
         // Data returned while fetch is still waiting: retire the access and
         // bubble EX/MEM so the request is not issued a second time.
         ctl.memwb_en    = 1'b1;
         ctl.exmem_flush = 1'b1;
      end else if (advance && redirect) begin
         ctl            = CTRL_ADVANCE;
         ctl.ifid_flush = 1'b1;
         ctl.idex_flush = 1'b1;
      end else if (advance && load_use) begin
         ctl            = CTRL_ADVANCE;
         ctl.pc_en      = 1'b0;
         ctl.ifid_en    = 1'b0;
         ctl.idex_flush = 1'b1;
      end else if (advance) begin
         ctl = CTRL_ADVANCE;
      end

      case (state_reg)
         RUN:     if (mem_stall) state_next = DWAIT;
         DWAIT:   if (dhit)      state_next = RUN;
         HALTED:  state_next = HALTED;
         default: state_next = RUN;
      endcase
      if (wb_halt) state_next = HALTED;

      halt_next = halt_reg | wb_halt;

      stall_cnt_next = stall_cnt_reg;
      if (state_reg != HALTED && !ctl.pc_en && stall_cnt_reg != '1)
         stall_cnt_next = stall_cnt_reg + CNT_W'(1);
   end

   assign pc_en       = ctl.pc_en;
   assign ifid_en     = ctl.ifid_en;
   assign idex_en     = ctl.idex_en;
   assign exmem_en    = ctl.exmem_en;
   assign memwb_en    = ctl.memwb_en;
   assign ifid_flush  = ctl.ifid_flush;
   assign idex_flush  = ctl.idex_flush;
   assign exmem_flush = ctl.exmem_flush;
   assign memwb_flush = ctl.memwb_flush;
   assign halt        = halt_reg;
   assign ctrl_state  = state_reg;
   assign stall_cnt   = stall_cnt_reg;
endmodule

// File: doc/pipeline_ctrl.md
# pipeline_ctrl

Central stall/flush sequencer for the five-stage pipeline. It drives the `en`/`flush` controls of the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC enable. It arbitrates instruction-fetch waits, data-memory waits, load-use hazards, EX-stage redirects and halt retirement. It also holds a small FSM for outstanding data accesses and the sticky halt, plus a saturating stall-cycle counter.

## Interface
Parameters:
- `CNT_W`, 16: width of stall-cycle counter.

Ports:
- `CLK`  in  1  system clock, rising edge.
- `nRST`  in  1  reset, asynchronous, active-low.
- `ihit`  in  1  instruction memory returned fetch this cycle.
- `dhit`  in  1  data memory completed access this cycle.
- `mem_dREN`, `mem_dWEN`  in  1 each  EX/MEM latch outputs: MEM-stage instruction is a load/store.
- `ex_dREN`  in  1  ID/EX latch output: EX-stage instruction is a load.
- `ex_wsel`  in  regbits_t  EX-stage destination register.
- `id_rs`, `id_rt`  in  regbits_t  ID-stage source registers.
- `redirect`  in  1  EX resolved taken branch/jump; PC mux selects target.
- `wb_halt`  in  1  MEM/WB latch `halt_o`.
- `pc_en`  out  1  PC register load.
- `ifid_en`, `idex_en`, `exmem_en`, `memwb_en`  out  1 each  latch enables.
- `ifid_flush`, `idex_flush`, `exmem_flush`, `memwb_flush`  out  1 each  latch synchronous clears (flush beats en inside latch).
- `halt`  out  1  sticky halt to system.
- `ctrl_state`  out  ctrl_state_t  FSM state, debug.
- `stall_cnt`  out  CNT_W  saturating count of stalled cycles.

## Operation
- Derived terms: `mem_op = mem_dREN|mem_dWEN`; `mem_stall = mem_op & ~dhit`; `load_use = ex_dREN & (ex_wsel!=0) & (ex_wsel==id_rs | ex_wsel==id_rt)`; `advance = ihit & ~mem_stall`.
- FSM states: RUN, DWAIT, HALTED.
  - RUN→DWAIT when `mem_stall`.
  - DWAIT→RUN on `dhit`.
  - Any state→HALTED when `wb_halt`.
  - HALTED exits only on reset.
- HALTED: all en=0, all flush=0, `pc_en=0`, `halt=1`.
- Priority in RUN/DWAIT: halt > mem_stall > dhit-without-ihit > redirect > load_use > fetch wait.
- `mem_stall`: all en=0, all flush=0, `pc_en=0`.
- `mem_op & dhit & ~ihit`:
  - `memwb_en=1` retires the access; `exmem_flush=1` inserts a bubble so the request is not reissued.
  - IF/ID, ID/EX, PC hold.
- `advance & redirect`:
  - All en=1, `pc_en=1`.
  - `ifid_flush=1`, `idex_flush=1`.
  - load_use ignored, since the dependent instruction is squashed.
- `advance & load_use & ~redirect`:
  - `pc_en=0`, `ifid_en=0`.
  - `idex_flush=1`.
  - `exmem_en=memwb_en=1`.
- `advance` otherwise: all en=1, `pc_en=1`, no flush.
- `~ihit & ~mem_op`: all en=0, `pc_en=0` (fetch wait).
- `stall_cnt`: increments each cycle not in HALTED where `pc_en=0`; saturates at all-ones; frozen in HALTED.

## Timing
- All latch/PC controls are combinational from inputs and the registered state, with zero-cycle latency. They take effect at the next rising `CLK`.
- `ctrl_state`, `halt`, `stall_cnt` are registered. `halt` asserts the cycle after `wb_halt` is sampled.
- Reset (async, any time, including mid-DWAIT):
  - `ctrl_state=RUN`, `halt=0`, `stall_cnt=0`.
  - Combinational outputs follow the RUN rules, with no outstanding-access memory retained.
- `dhit` with `~mem_op` is ignored.
- `wb_halt` and `mem_stall` in the same cycle: halt wins, and the next state is HALTED.
- Flushes are single-cycle pulses generated only on the qualifying cycle. No flush persists across a stall.

## Structure
- Add `ctrl_state_t` (enum logic [1:0]: RUN, DWAIT, HALTED) to `cpu_types_pkg`.
- Add `pipeline_ctrl_if` interface with modport `pc` carrying the ports above.
- Single module; load-use comparator as sub-module `hazard_detect` (pure combinational, outputs `load_use`).

## Test plan
- Reset mid-DWAIT: drop `nRST` while `mem_dREN=1`, `dhit=0` → `ctrl_state=RUN`, `halt=0`, `stall_cnt=0` immediately. After release with `ihit=1` and `mem_op=0` → all en=1.
- Load miss 3 cycles: `mem_dREN=1`, `dhit` low for 3 cycles then high with `ihit=0` → 3 cycles all en=0 in DWAIT. Then `memwb_en=1`, `exmem_flush=1`, `pc_en=0`; `stall_cnt=4`.
- Load-use: `ex_dREN=1`, `ex_wsel=5`, `id_rt=5`, `ihit=1` → `pc_en=0`, `ifid_en=0`, `idex_flush=1`, `exmem_en=1`.
- Load-use with `ex_wsel=0`: same stimulus with register 0 → no stall, all en=1.
- Redirect and load-use together → `ifid_flush=idex_flush=1`, `pc_en=1`, no hold.
- Halt: `wb_halt=1` → next cycle `halt=1`, HALTED, all en=0. Later `ihit=1`, `redirect=1` → no change; `stall_cnt` frozen.
- Saturation with `CNT_W=4`: 20 fetch-wait cycles → `stall_cnt=15`.
